// File: rtl/img_rsz_blk_sched_pkg.sv
// rtl/img_rsz_blk_sched_pkg.sv - shared types and constants for the block-pooling resizer
package ImgRszPkg;

    localparam int PXL_PRIM_COLOR_W     = 8;
    localparam int RSZ_IMG_WIDTH_SIZE   = 32;
    localparam int RSZ_IMG_HEIGHT_SIZE  = 32;
    localparam int RSZ_IMG_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE);
    localparam int RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE);
    localparam int BLK_WIDTH_MAX_SZ_W   = 5;
    localparam int BLK_HEIGHT_MAX_SZ_W  = 5;
    localparam int BW_LOG2_W            = $clog2(BLK_WIDTH_MAX_SZ_W + 1);
    localparam int BH_LOG2_W            = $clog2(BLK_HEIGHT_MAX_SZ_W + 1);
    // A full block of maximum-valued pixels never overflows this width.
    localparam int BLK_SUM_MAX_W        = PXL_PRIM_COLOR_W + BLK_WIDTH_MAX_SZ_W + BLK_HEIGHT_MAX_SZ_W;

    typedef logic [PXL_PRIM_COLOR_W-1:0] PxlPrim_t;
    typedef logic [BLK_SUM_MAX_W-1:0]    BlkVal_t;

    typedef struct packed {
        BlkVal_t r;
        BlkVal_t g;
        BlkVal_t b;
    } FcBlkVal_t;

    typedef struct packed {
        PxlPrim_t r;
        PxlPrim_t g;
        PxlPrim_t b;
    } FcRszPxlData_t;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} SchedState_t;

endpackage

// File: rtl/img_rsz_blk_sched_pos.sv
// rtl/img_rsz_blk_sched_pos.sv - raster position counters for the block scheduler
// Module img_rsz_pos_cnt.
// Ports: clk, rst_n (async active-low), clear (restart at frame origin),
//        advance (one accepted pixel), rowAdvance (next block-row),
//        bwLog2/bhLog2 (latched block size), pxCol/blkCol/pxRow/blkRow positions,
//        pxColWrap/blkColWrap/pxRowWrap (current position is the last of its range).
module img_rsz_pos_cnt
    import ImgRszPkg::*;
#(
    parameter int RSZ_W = RSZ_IMG_WIDTH_SIZE,
    parameter int RSZ_H = RSZ_IMG_HEIGHT_SIZE
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            advance,
    input  logic                            rowAdvance,
    input  logic [BW_LOG2_W-1:0]            bwLog2,
    input  logic [BH_LOG2_W-1:0]            bhLog2,
    output logic [BLK_WIDTH_MAX_SZ_W-1:0]   pxCol,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  blkCol,
    output logic [BLK_HEIGHT_MAX_SZ_W-1:0]  pxRow,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] blkRow,
    output logic                            pxColWrap,
    output logic                            blkColWrap,
    output logic                            pxRowWrap
);

    // One bit wider than the counters so that 1 << max still fits before the -1.
    logic [BLK_WIDTH_MAX_SZ_W:0]  pxColLimit;
    logic [BLK_HEIGHT_MAX_SZ_W:0] pxRowLimit;

    assign pxColLimit = ((BLK_WIDTH_MAX_SZ_W+1)'(1) << bwLog2) - (BLK_WIDTH_MAX_SZ_W+1)'(1);
    assign pxRowLimit = ((BLK_HEIGHT_MAX_SZ_W+1)'(1) << bhLog2) - (BLK_HEIGHT_MAX_SZ_W+1)'(1);

    assign pxColWrap  = (pxCol == pxColLimit[BLK_WIDTH_MAX_SZ_W-1:0]);
    assign pxRowWrap  = (pxRow == pxRowLimit[BLK_HEIGHT_MAX_SZ_W-1:0]);
    assign blkColWrap = (blkCol == RSZ_IMG_WIDTH_IDX_W'(RSZ_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pxCol  <= '0;
            blkCol <= '0;
            pxRow  <= '0;
            blkRow <= '0;
        end else if (clear) begin
            pxCol  <= '0;
            blkCol <= '0;
            pxRow  <= '0;
            blkRow <= '0;
        end else begin
            if (advance) begin
                if (!pxColWrap) begin
                    pxCol <= pxCol + 1'b1;
                end else begin
                    pxCol <= '0;
                    if (!blkColWrap) begin
                        blkCol <= blkCol + 1'b1;
                    end else begin
                        blkCol <= '0;
                        pxRow  <= pxRowWrap ? '0 : pxRow + 1'b1;
                    end
                end
            end
            // Block-row moves only after the drain, so out_row shows the row being drained.
            if (rowAdvance) begin
                blkRow <= blkRow + 1'b1;
            end
        end
    end

endmodule

// File: rtl/img_rsz_blk_sched.sv
// rtl/img_rsz_blk_sched.sv - block-pooling scheduler: accumulate one block-row, then drain it
// Optional macro IMG_RSZ_MAX_POOL_EN selects max pooling instead of average pooling.
// Ports: clk, rst_n (async active-low); cfg_start/cfg_bw_log2/cfg_bh_log2 frame setup;
//        in_valid/in_ready/in_data raster pixel input; out_valid/out_ready/out_data
//        resized pixel output with out_col/out_row/out_last; busy, frame_done status.
module img_rsz_blk_sched
    import ImgRszPkg::*;
#(
    parameter int RSZ_W = RSZ_IMG_WIDTH_SIZE,
    parameter int RSZ_H = RSZ_IMG_HEIGHT_SIZE
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_start,
    input  logic [BW_LOG2_W-1:0]            cfg_bw_log2,
    input  logic [BH_LOG2_W-1:0]            cfg_bh_log2,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  FcRszPxlData_t                   in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output FcRszPxlData_t                   out_data,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  out_col,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] out_row,
    output logic                            out_last,
    output logic                            busy,
    output logic                            frame_done
);

`ifdef IMG_RSZ_MAX_POOL_EN
    typedef FcRszPxlData_t BufEntry_t;
`else
    typedef FcBlkVal_t BufEntry_t;
`endif

    localparam logic [RSZ_IMG_WIDTH_IDX_W-1:0]  LAST_COL = RSZ_IMG_WIDTH_IDX_W'(RSZ_W - 1);
    localparam logic [RSZ_IMG_HEIGHT_IDX_W-1:0] LAST_ROW = RSZ_IMG_HEIGHT_IDX_W'(RSZ_H - 1);

    SchedState_t                     state, stateNext;
    logic [BW_LOG2_W-1:0]            bwLog2Q;
    logic [BH_LOG2_W-1:0]            bhLog2Q;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  drainIdx;
    logic [BLK_WIDTH_MAX_SZ_W-1:0]   pxCol;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  blkCol;
    logic [BLK_HEIGHT_MAX_SZ_W-1:0]  pxRow;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] blkRow;
    logic                            pxColWrap, blkColWrap, pxRowWrap;
    logic                            cntClear, rowAdvance, accept, drainHs, drainEnd;
    BufEntry_t                       blkBuf [RSZ_W];
    BufEntry_t                       curEntry, nextEntry, drainEntry;

    assign accept   = in_valid && in_ready;
    assign drainHs  = (state == DRAIN) && out_ready;
    assign drainEnd = drainHs && (drainIdx == LAST_COL);

    img_rsz_pos_cnt #(.RSZ_W(RSZ_W), .RSZ_H(RSZ_H)) posCnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cntClear),
        .advance   (accept),
        .rowAdvance(rowAdvance),
        .bwLog2    (bwLog2Q),
        .bhLog2    (bhLog2Q),
        .pxCol     (pxCol),
        .blkCol    (blkCol),
        .pxRow     (pxRow),
        .blkRow    (blkRow),
        .pxColWrap (pxColWrap),
        .blkColWrap(blkColWrap),
        .pxRowWrap (pxRowWrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bwLog2Q    <= '0;
            bhLog2Q    <= '0;
            drainIdx   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= stateNext;
            frame_done <= drainEnd && (blkRow == LAST_ROW);
            if (state == IDLE && cfg_start) begin
                bwLog2Q  <= (cfg_bw_log2 > BW_LOG2_W'(BLK_WIDTH_MAX_SZ_W))
                            ? BW_LOG2_W'(BLK_WIDTH_MAX_SZ_W) : cfg_bw_log2;
                bhLog2Q  <= (cfg_bh_log2 > BH_LOG2_W'(BLK_HEIGHT_MAX_SZ_W))
                            ? BH_LOG2_W'(BLK_HEIGHT_MAX_SZ_W) : cfg_bh_log2;
                drainIdx <= '0;
            end else if (drainHs) begin
                drainIdx <= drainEnd ? '0 : drainIdx + 1'b1;
            end
        end
    end

    always_comb begin
        stateNext  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        cntClear   = 1'b0;
        rowAdvance = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    stateNext = ACCUM;
                    cntClear  = 1'b1;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && pxColWrap && blkColWrap && pxRowWrap) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (drainEnd) begin
                    if (blkRow == LAST_ROW) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext  = ACCUM;
                        rowAdvance = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // The first pixel of each block (top-left) overwrites the stale entry from the previous block-row.
    always_comb begin
        curEntry = blkBuf[blkCol];
`ifdef IMG_RSZ_MAX_POOL_EN
        if (pxCol == '0 && pxRow == '0) begin
            nextEntry = in_data;
        end else begin
            nextEntry.r = (in_data.r > curEntry.r) ? in_data.r : curEntry.r;
            nextEntry.g = (in_data.g > curEntry.g) ? in_data.g : curEntry.g;
            nextEntry.b = (in_data.b > curEntry.b) ? in_data.b : curEntry.b;
        end
`else
        if (pxCol == '0 && pxRow == '0) begin
            nextEntry.r = BlkVal_t'(in_data.r);
            nextEntry.g = BlkVal_t'(in_data.g);
            nextEntry.b = BlkVal_t'(in_data.b);
        end else begin
            nextEntry.r = curEntry.r + BlkVal_t'(in_data.r);
            nextEntry.g = curEntry.g + BlkVal_t'(in_data.g);
            nextEntry.b = curEntry.b + BlkVal_t'(in_data.b);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSZ_W; i++) begin
                blkBuf[i] <= '0;
            end
        end else if (accept) begin
            blkBuf[blkCol] <= nextEntry;
        end
    end

`ifdef IMG_RSZ_MAX_POOL_EN
    always_comb begin
        drainEntry = blkBuf[drainIdx];
        out_data   = drainEntry;
    end
`else
    logic [BW_LOG2_W:0] shiftAmt;
    assign shiftAmt = {1'b0, bwLog2Q} + {1'b0, bhLog2Q};

    always_comb begin
        drainEntry = blkBuf[drainIdx];
        out_data.r = PxlPrim_t'(drainEntry.r >> shiftAmt);
        out_data.g = PxlPrim_t'(drainEntry.g >> shiftAmt);
        out_data.b = PxlPrim_t'(drainEntry.b >> shiftAmt);
    end
`endif

    assign out_col  = drainIdx;
    assign out_row  = blkRow;
    assign out_last = (state == DRAIN) && (drainIdx == LAST_COL) && (blkRow == LAST_ROW);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_img_rsz_blk_sched.sv
// tb/tb_img_rsz_blk_sched.sv - scoreboard bench for img_rsz_blk_sched
module tb_img_rsz_blk_sched;
    import ImgRszPkg::*;

    localparam int NW = RSZ_IMG_WIDTH_SIZE;
    localparam int NH = RSZ_IMG_HEIGHT_SIZE;

    typedef struct {
        logic [23:0] data;
        int          col;
        int          row;
        logic        last;
    } Exp_t;

    logic                            clk = 1'b0;
    logic                            rst_n = 1'b0;
    logic                            cfg_start = 1'b0;
    logic [BW_LOG2_W-1:0]            cfg_bw_log2 = '0;
    logic [BH_LOG2_W-1:0]            cfg_bh_log2 = '0;
    logic                            in_valid = 1'b0;
    logic                            in_ready;
    FcRszPxlData_t                   in_data = '0;
    logic                            out_valid;
    logic                            out_ready = 1'b0;
    FcRszPxlData_t                   out_data;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  out_col;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] out_row;
    logic                            out_last;
    logic                            busy;
    logic                            frame_done;

    Exp_t sb[$];
    int   nChecks = 0;
    int   nFails  = 0;

    img_rsz_blk_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_bw_log2(cfg_bw_log2),
        .cfg_bh_log2(cfg_bh_log2),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_row    (out_row),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic FcRszPxlData_t genPix(input int x, input int y, input int pat);
        FcRszPxlData_t p;
        case (pat)
            0: begin
                p.r = 8'(x + y);
                p.g = 8'(x + y + 1);
                p.b = 8'(x + y + 2);
            end
            1: begin
                if (x < 2 && y < 2) begin
                    p.r = 8'(10 + y * 2 + x);
                    p.g = p.r;
                    p.b = p.r;
                end else begin
                    p = '0;
                end
            end
            2:       p = FcRszPxlData_t'($urandom);
            default: p = '1;
        endcase
        return p;
    endfunction

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_in_ready"},   in_ready,   1'b0);
        chk({tag, "_out_valid"},  out_valid,  1'b0);
        chk({tag, "_out_last"},   out_last,   1'b0);
        chk({tag, "_busy"},       busy,       1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
    endtask

    task automatic drainRow(input bit toggle);
        Exp_t        e;
        int          got;
        int          cyc;
        bit          tog;
        bit          held;
        logic [23:0] hData;
        logic [4:0]  hCol;
        got  = 0;
        cyc  = 0;
        tog  = 1'b0;
        held = 1'b0;
        while (got < NW && cyc < 200) begin
            @(negedge clk);
            cyc++;
            tog       = toggle ? ~tog : 1'b1;
            out_ready = tog;
            in_valid  = 1'b1;
            in_data   = FcRszPxlData_t'($urandom);
            if (cyc == 1) chk("first_out_latency", out_valid, 1'b1);
            chk("in_ready_in_drain", in_ready, 1'b0);
            if (held) begin
                chk("stall_data", out_data, hData);
                chk("stall_col", out_col, hCol);
                held = 1'b0;
            end
            if (out_valid) begin
                if (out_ready) begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_col", out_col, e.col);
                    chk("out_row", out_row, e.row);
                    chk("out_last", out_last, e.last);
                    got++;
                end else begin
                    held  = 1'b1;
                    hData = out_data;
                    hCol  = out_col;
                end
            end
        end
        if (got < NW) chk("drain_timeout", got, NW);
    endtask

    task automatic runFrame(input int bw, input int bh, input int pat, input bit toggle,
                            input int nRows, input bit abortHalf);
        int            bwS, bhS, w, h, lim, x, y, wt;
        int            sums[NW][3];
        int            v[3];
        FcRszPxlData_t p;
        Exp_t          e;
        bwS = (bw > 5) ? 5 : bw;
        bhS = (bh > 5) ? 5 : bh;
        w   = NW << bwS;
        h   = 1 << bhS;
        sb.delete();
        @(negedge clk);
        cfg_bw_log2 = BW_LOG2_W'(bw);
        cfg_bh_log2 = BH_LOG2_W'(bh);
        cfg_start   = 1'b1;
        @(negedge clk);
        cfg_start   = 1'b0;
        cfg_bw_log2 = '0;
        cfg_bh_log2 = '0;
        chk("busy_after_start", busy, 1'b1);
        chk("in_ready_accum", in_ready, 1'b1);
        for (int r = 0; r < nRows + (abortHalf ? 1 : 0); r++) begin
            lim = (abortHalf && r == nRows) ? (w * h) / 2 : w * h;
            for (int b = 0; b < NW; b++) for (int c = 0; c < 3; c++) sums[b][c] = 0;
            for (int k = 0; k < lim; k++) begin
                x = k % w;
                y = k / w;
                @(negedge clk);
                p        = genPix(x, r * h + y, pat);
                in_valid = 1'b1;
                in_data  = p;
                wt = 0;
                while (!in_ready && wt < 20) begin
                    @(negedge clk);
                    wt++;
                end
                if (wt == 20) chk("in_ready_timeout", in_ready, 1'b1);
                v[0] = p.r;
                v[1] = p.g;
                v[2] = p.b;
                for (int c = 0; c < 3; c++) begin
`ifdef IMG_RSZ_MAX_POOL_EN
                    if (v[c] > sums[x >> bwS][c]) sums[x >> bwS][c] = v[c];
`else
                    sums[x >> bwS][c] += v[c];
`endif
                end
            end
            if (lim != w * h) break;
            for (int b = 0; b < NW; b++) begin
`ifdef IMG_RSZ_MAX_POOL_EN
                e.data = {8'(sums[b][0]), 8'(sums[b][1]), 8'(sums[b][2])};
`else
                e.data = {8'(sums[b][0] >> (bwS + bhS)), 8'(sums[b][1] >> (bwS + bhS)),
                          8'(sums[b][2] >> (bwS + bhS))};
`endif
                e.col  = b;
                e.row  = r;
                e.last = (r == NH - 1) && (b == NW - 1);
                sb.push_back(e);
            end
            drainRow(toggle);
        end
        if (nRows < NH) begin
            @(negedge clk);
            in_valid = 1'b0;
            rst_n    = 1'b0;
            #1;
            checkResetOutputs("mid_reset");
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk("frame_done_pulse", frame_done, 1'b1);
            chk("busy_idle", busy, 1'b0);
            chk("out_valid_idle", out_valid, 1'b0);
            chk("in_ready_idle", in_ready, 1'b0);
            @(negedge clk);
            chk("frame_done_clear", frame_done, 1'b0);
        end
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        #1;
        checkResetOutputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkResetOutputs("idle");
        runFrame(0, 0, 0, 1'b0, NH, 1'b0);
        runFrame(1, 1, 1, 1'b0, NH, 1'b0);
        runFrame(1, 0, 2, 1'b1, NH, 1'b0);
        runFrame(0, 0, 2, 1'b0, 3, 1'b1);
        runFrame(2, 1, 2, 1'b0, NH, 1'b0);
        runFrame(0, 7, 3, 1'b0, 1, 1'b0);
        runFrame(1, 1, 2, 1'b1, NH, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
